gpu_frame_scheduler: RTL and testbench
======================================

Name: gpu_frame_scheduler

Overview:
Sequences the GPU pipeline one frame at a time. It holds the host-written shadow transform matrix and vertex count, and copies them atomically into the active set seen by the GPU. It issues a single-cycle start pulse, then tracks frame_end so that the active set never changes while a frame is in flight. It sits between the host register interface and the GPU top-level start, vertex_count and transform_matrix inputs.

Parameters:
M, 11, integer bits of fixed-point matrix element
N, 7, fractional bits of fixed-point matrix element
VERTEX_MEM_DEPTH, 16384, vertex memory depth; bounds vertex_count
FRAME_CNT_W, 16, width of frame and drop counters
TIMEOUT_CYCLES, 2**24, watchdog limit (optional feature only)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
host_mtx_we  in  1  write one shadow matrix element
host_mtx_idx  in  4  shadow element index 0..15
host_mtx_data  in  M+N  signed shadow element value
host_vcount  in  32  shadow vertex count, sampled on commit
host_commit  in  1  pulse: shadow set is complete and valid
frame_tick  in  1  pulse: frame request (vsync or host trigger)
frame_end  in  1  GPU frame_end level
gpu_start  out  1  single-cycle start pulse to GPU
gpu_vertex_count  out  32  active vertex count
gpu_transform_matrix  out  (M+N)x16  signed active matrix
busy  out  1  frame in flight
frame_cnt  out  FRAME_CNT_W  completed frames
drop_cnt  out  FRAME_CNT_W  frame_ticks not serviced
timeout  out  1  sticky watchdog flag (optional feature)

Behaviour:
- Reset (async assert, sync deassert handled externally): state IDLE. All outputs 0. Active and shadow matrices 0. commit_pending=0.
- Shadow writes are accepted in any state. host_mtx_we writes shadow[idx] in 1 cycle.
- host_commit latches host_vcount into shadow_vcount and sets commit_pending.
- Clamp: a vcount greater than VERTEX_MEM_DEPTH is stored as VERTEX_MEM_DEPTH. The low 2 bits are cleared so the count is a multiple of 4.
- A shadow write and a commit in the same cycle: the write lands first, and the commit includes it.
- FSM:
  - IDLE: on frame_tick with frame_end=1, go to LOAD. A frame_tick with frame_end=0 increments drop_cnt and stays in IDLE.
  - LOAD (1 cycle): if commit_pending, copy shadow to active and clear commit_pending. Otherwise keep the previous active set. A commit in this same cycle is deferred to the next frame. Go to START.
  - START (1 cycle): gpu_start=1 and busy=1. Skip the frame if gpu_vertex_count==0: go to IDLE and increment frame_cnt. Otherwise go to ACK.
  - ACK: wait for frame_end=0, which the GPU drops 1 cycle after start, then go to RUN. If frame_end is still 1 after 4 cycles, go to RUN anyway.
  - RUN: on the frame_end 0->1 edge, go to DONE.
  - DONE (1 cycle): increment frame_cnt (wraps), busy=0, go to IDLE.
- A frame_tick in any state other than IDLE increments drop_cnt; the tick is not queued. drop_cnt and frame_cnt wrap at 2**FRAME_CNT_W.
- gpu_transform_matrix and gpu_vertex_count change only in LOAD. They are stable from gpu_start until DONE.
- Latency: frame_tick to gpu_start is 2 cycles.

Optional Feature:
- Macro: GPU_FRAME_SCHEDULER_WATCHDOG_EN.
- Defined: a cycle counter runs in ACK and RUN. When it reaches TIMEOUT_CYCLES:
  - set timeout (sticky; cleared only by reset);
  - go to IDLE with busy=0;
  - do not increment frame_cnt.
- Undefined: no counter is built; timeout is tied to 0; RUN waits indefinitely.

Decomposition:
- Package gpu_pkg:
  - localparams M, N;
  - typedef fixed_t = logic signed [M+N-1:0];
  - typedef mtx_t = fixed_t [0:15];
  - enum sched_state_e {IDLE, LOAD, START, ACK, RUN, DONE}.
- One sub-module, gpu_matrix_shadow: the shadow/active register pair with write port, commit latch and copy enable. The FSM, counters and watchdog stay in the top.

Test Plan:
- Reset mid-RUN (reset_n=0 for 1 cycle) -> all outputs 0, state IDLE, active matrix 0.
- Write identity (0x80 on the diagonal, i.e. 1.0 with N=7), vcount=12, commit, frame_tick with frame_end=1 -> gpu_start exactly 2 cycles after tick, one cycle wide. Active matrix equals identity, vertex_count=12. After frame_end rises, frame_cnt=1 and busy=0.
- Commit a new matrix during RUN -> active matrix unchanged until the next LOAD, then updated. Commit in the same cycle as LOAD -> applied one frame later.
- vcount=20000 -> gpu_vertex_count=16384. vcount=13 -> 12. vcount=0 -> start pulse issued, no RUN, frame_cnt increments.
- Three frame_ticks during RUN -> drop_cnt=3, no extra gpu_start. drop_cnt wraps from 0xFFFF to 0.
- With the watchdog macro and TIMEOUT_CYCLES=100, frame_end held at 0 -> timeout=1 at cycle 100 of ACK/RUN, state IDLE, frame_cnt unchanged.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared types and constants for the GPU frame scheduler.
//   M, N            : integer / fractional bits of a fixed-point matrix element
//   fixed_t, mtx_t  : signed element and 4x4 matrix (16 elements, row-major)
//   sched_state_e   : scheduler FSM states
//   clamp_vcount    : bounds a host vertex count to memory depth, multiple of 4
package gpu_pkg;

    localparam int unsigned M = 11;
    localparam int unsigned N = 7;

    typedef logic signed [M+N-1:0] fixed_t;
    typedef fixed_t [0:15] mtx_t;

    typedef enum logic [2:0] {IDLE, LOAD, START, ACK, RUN, DONE} sched_state_e;

    function automatic logic [31:0] clamp_vcount(input logic [31:0] vc,
                                                 input int unsigned depth);
        logic [31:0] bounded;
        bounded = (vc > 32'(depth)) ? 32'(depth) : vc;
        // The GPU consumes vertices in groups of 4.
        return bounded & ~32'h3;
    endfunction

endpackage

// File: rtl/gpu_frame_scheduler_if.sv
// Host register bus into the frame scheduler.
//   host_mtx_we/idx/data : single shadow matrix element write
//   host_vcount          : shadow vertex count, sampled on commit
//   host_commit          : shadow set complete and valid
// master: host side (drives), slave: scheduler side (receives).
interface gpu_frame_scheduler_if;
    import gpu_pkg::*;

    logic        host_mtx_we;
    logic [3:0]  host_mtx_idx;
    fixed_t      host_mtx_data;
    logic [31:0] host_vcount;
    logic        host_commit;

    modport master (
        output host_mtx_we, host_mtx_idx, host_mtx_data, host_vcount, host_commit
    );
    modport slave (
        input host_mtx_we, host_mtx_idx, host_mtx_data, host_vcount, host_commit
    );

endinterface

// File: rtl/gpu_matrix_shadow.sv
// Shadow/active register pair for the transform matrix and vertex count.
//   wr_en_i/wr_idx_i/wr_data_i : shadow element write (any time)
//   commit_i/commit_vcount_i   : latch clamped vcount, mark shadow set pending
//   copy_en_i                  : copy shadow to active if a commit is pending
//   active_mtx_o/active_vcount_o : set seen by the GPU
//   commit_pending_o           : a committed shadow set awaits the next copy
module gpu_matrix_shadow
    import gpu_pkg::*;
#(
    parameter int unsigned VERTEX_MEM_DEPTH = 16384
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_en_i,
    input  logic [3:0]  wr_idx_i,
    input  fixed_t      wr_data_i,
    input  logic        commit_i,
    input  logic [31:0] commit_vcount_i,
    input  logic        copy_en_i,
    output mtx_t        active_mtx_o,
    output logic [31:0] active_vcount_o,
    output logic        commit_pending_o
);

    mtx_t        shadow_q, shadow_d, active_q, active_d;
    logic [31:0] shadow_vcount_q, shadow_vcount_d, active_vcount_q, active_vcount_d;
    logic        pending_q, pending_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q        <= '0;
            shadow_vcount_q <= '0;
            active_q        <= '0;
            active_vcount_q <= '0;
            pending_q       <= 1'b0;
        end else begin
            shadow_q        <= shadow_d;
            shadow_vcount_q <= shadow_vcount_d;
            active_q        <= active_d;
            active_vcount_q <= active_vcount_d;
            pending_q       <= pending_d;
        end
    end

    always_comb begin
        shadow_d        = shadow_q;
        shadow_vcount_d = shadow_vcount_q;
        active_d        = active_q;
        active_vcount_d = active_vcount_q;
        pending_d       = pending_q;
        if (wr_en_i) begin
            shadow_d[wr_idx_i] = wr_data_i;
        end
        // The copy reads registered shadow state, so a same-cycle commit is
        // left pending for the following frame.
        if (copy_en_i && pending_q) begin
            active_d        = shadow_q;
            active_vcount_d = shadow_vcount_q;
            pending_d       = 1'b0;
        end
        if (commit_i) begin
            shadow_vcount_d = clamp_vcount(commit_vcount_i, VERTEX_MEM_DEPTH);
            pending_d       = 1'b1;
        end
    end

    assign active_mtx_o     = active_q;
    assign active_vcount_o  = active_vcount_q;
    assign commit_pending_o = pending_q;

endmodule

// File: rtl/gpu_frame_scheduler.sv
// Frame scheduler: atomically applies the host shadow set and sequences one
// GPU frame at a time (IDLE -> LOAD -> START -> ACK -> RUN -> DONE).
//   host                 : host register bus (slave modport)
//   frame_tick           : frame request pulse
//   frame_end            : GPU frame_end level
//   gpu_start            : single-cycle start pulse
//   gpu_vertex_count/gpu_transform_matrix : active set, changes only in LOAD
//   busy, frame_cnt, drop_cnt : status
//   timeout              : sticky watchdog flag
// Optional feature macro: GPU_FRAME_SCHEDULER_WATCHDOG_EN (ACK/RUN watchdog).
module gpu_frame_scheduler
    import gpu_pkg::*;
#(
    parameter int unsigned VERTEX_MEM_DEPTH = 16384,
    parameter int unsigned FRAME_CNT_W      = 16
`ifdef GPU_FRAME_SCHEDULER_WATCHDOG_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES   = 2**24
`endif
) (
    input  logic                   clk,
    input  logic                   reset_n,
    gpu_frame_scheduler_if.slave   host,
    input  logic                   frame_tick,
    input  logic                   frame_end,
    output logic                   gpu_start,
    output logic [31:0]            gpu_vertex_count,
    output mtx_t                   gpu_transform_matrix,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic [FRAME_CNT_W-1:0] drop_cnt,
    output logic                   timeout
);

    sched_state_e           state_q, state_d;
    logic [1:0]             ack_cnt_q, ack_cnt_d;
    logic                   frame_end_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;
    logic                   copy_en;
    logic                   commit_pending;
    logic                   wd_expire;

    gpu_matrix_shadow #(
        .VERTEX_MEM_DEPTH(VERTEX_MEM_DEPTH)
    ) u_shadow (
        .clk             (clk),
        .reset_n         (reset_n),
        .wr_en_i         (host.host_mtx_we),
        .wr_idx_i        (host.host_mtx_idx),
        .wr_data_i       (host.host_mtx_data),
        .commit_i        (host.host_commit),
        .commit_vcount_i (host.host_vcount),
        .copy_en_i       (copy_en),
        .active_mtx_o    (gpu_transform_matrix),
        .active_vcount_o (gpu_vertex_count),
        .commit_pending_o(commit_pending)
    );

`ifdef GPU_FRAME_SCHEDULER_WATCHDOG_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WdW-1:0] wd_q, wd_d;
    logic           timeout_q, timeout_d;
    logic           wd_active;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        wd_active = (state_q == ACK) || (state_q == RUN);
        // wd_q counts completed ACK/RUN cycles; expire on the last allowed one.
        wd_expire = wd_active && (wd_q == WdW'(TIMEOUT_CYCLES - 1));
        wd_d      = (wd_active && !wd_expire) ? wd_q + WdW'(1) : '0;
        timeout_d = timeout_q | wd_expire;
    end

    assign timeout = timeout_q;
`else
    assign wd_expire = 1'b0;
    assign timeout   = 1'b0;
`endif

    // State register and counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ack_cnt_q   <= '0;
            frame_end_q <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            ack_cnt_q   <= ack_cnt_d;
            frame_end_q <= frame_end;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Next state and counter updates.
    always_comb begin
        state_d     = state_q;
        ack_cnt_d   = '0;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        case (state_q)
            IDLE:  if (frame_tick && frame_end) state_d = LOAD;
            LOAD:  state_d = START;
            START: begin
                if (gpu_vertex_count == '0) begin
                    state_d     = IDLE;
                    frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
                end else begin
                    state_d = ACK;
                end
            end
            ACK: begin
                ack_cnt_d = ack_cnt_q + 2'd1;
                // Fall through to RUN after 4 cycles if the GPU never drops frame_end.
                if (!frame_end || (ack_cnt_q == 2'd3)) state_d = RUN;
            end
            RUN:   if (frame_end && !frame_end_q) state_d = DONE;
            DONE: begin
                state_d     = IDLE;
                frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
        if (wd_expire) state_d = IDLE;
        // Ticks outside IDLE, or while the GPU is not idle, are dropped, not queued.
        if (frame_tick && ((state_q != IDLE) || !frame_end)) begin
            drop_cnt_d = drop_cnt_q + FRAME_CNT_W'(1);
        end
    end

    // Moore outputs.
    always_comb begin
        gpu_start = (state_q == START);
        busy      = (state_q == START) || (state_q == ACK) || (state_q == RUN);
        copy_en   = (state_q == LOAD);
    end

    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_gpu_frame_scheduler.sv
// Self-checking bench for gpu_frame_scheduler: vcount clamp table, frame
// sequencing, deferred commits, drops and counter wrap, reset mid-frame.
module tb_gpu_frame_scheduler;
    import gpu_pkg::*;

    localparam int unsigned Fcw = 16;

    typedef struct {
        mtx_t        mtx;
        logic [31:0] vc;
    } exp_t;

    typedef struct {
        logic [31:0] vc_in;
        logic [31:0] vc_exp;
    } vec_t;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           frame_tick;
    logic           frame_end;
    logic           gpu_start;
    logic [31:0]    gpu_vertex_count;
    mtx_t           gpu_transform_matrix;
    logic           busy;
    logic [Fcw-1:0] frame_cnt;
    logic [Fcw-1:0] drop_cnt;
    logic           timeout;

    gpu_frame_scheduler_if host_if ();

    always #5 clk = ~clk;

    gpu_frame_scheduler #(
        .VERTEX_MEM_DEPTH(16384),
        .FRAME_CNT_W     (Fcw)
`ifdef GPU_FRAME_SCHEDULER_WATCHDOG_EN
        , .TIMEOUT_CYCLES(100)
`endif
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .host                (host_if),
        .frame_tick          (frame_tick),
        .frame_end           (frame_end),
        .gpu_start           (gpu_start),
        .gpu_vertex_count    (gpu_vertex_count),
        .gpu_transform_matrix(gpu_transform_matrix),
        .busy                (busy),
        .frame_cnt           (frame_cnt),
        .drop_cnt            (drop_cnt),
        .timeout             (timeout)
    );

    int checks = 0;
    int errors = 0;

    // Reference model of the shadow/active sets and counters.
    mtx_t           m_shadow, m_active, last_mtx, ident;
    logic [31:0]    m_svc, m_avc, last_vc;
    bit             m_pend;
    logic [Fcw-1:0] fc_exp, drop_exp;
    exp_t           sb[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_shadow = '0; m_active = '0; m_svc = '0; m_avc = '0; m_pend = 0;
        fc_exp = '0; drop_exp = '0;
        sb.delete();
    endtask

    task automatic write_elem(input int idx, input fixed_t d);
        host_if.host_mtx_we   = 1'b1;
        host_if.host_mtx_idx  = 4'(idx);
        host_if.host_mtx_data = d;
        step();
        host_if.host_mtx_we = 1'b0;
        m_shadow[idx] = d;
    endtask

    task automatic commit(input logic [31:0] vc_in, input logic [31:0] vc_exp);
        host_if.host_vcount = vc_in;
        host_if.host_commit = 1'b1;
        step();
        host_if.host_commit = 1'b0;
        m_svc  = vc_exp;
        m_pend = 1;
    endtask

    // Tick, wait for the start pulse (bounded) and compare the active set.
    task automatic start_frame(input bit commit_in_load, input logic [31:0] vc_in,
                               input logic [31:0] vc_exp);
        exp_t e;
        int   n;
        frame_tick = 1'b1;
        if (m_pend) begin
            m_active = m_shadow; m_avc = m_svc; m_pend = 0;
        end
        e.mtx = m_active; e.vc = m_avc;
        sb.push_back(e);
        step();
        frame_tick = 1'b0;
        n = 1;
        if (commit_in_load) begin
            host_if.host_vcount = vc_in;
            host_if.host_commit = 1'b1;
            step();
            host_if.host_commit = 1'b0;
            m_svc = vc_exp; m_pend = 1;
            n = 2;
        end
        while (!gpu_start && n < 10) begin
            step();
            n++;
        end
        check("start_latency", 320'(n), 320'(2));
        e = sb.pop_front();
        last_vc = e.vc; last_mtx = e.mtx;
        check("active_vcount", 320'(gpu_vertex_count), 320'(e.vc));
        check("active_matrix", 320'(gpu_transform_matrix), 320'(e.mtx));
        check("busy_at_start", 320'(busy), 320'(1));
    endtask

    // From START into RUN; GPU drops frame_end one cycle after start.
    task automatic ack_frame();
        step();
        check("start_one_cycle", 320'(gpu_start), 320'(0));
        frame_end = 1'b0;
        step();
    endtask

    task automatic end_frame();
        check("busy_run", 320'(busy), 320'(1));
        check("matrix_stable", 320'(gpu_transform_matrix), 320'(last_mtx));
        frame_end = 1'b1;
        step();
        step();
        fc_exp = fc_exp + Fcw'(1);
        check("frame_cnt", 320'(frame_cnt), 320'(fc_exp));
        check("busy_idle", 320'(busy), 320'(0));
    endtask

    task automatic finish_frame(input int run_len);
        if (last_vc == 0) begin
            step();
            fc_exp = fc_exp + Fcw'(1);
            check("skip_start_low", 320'(gpu_start), 320'(0));
            check("skip_busy", 320'(busy), 320'(0));
            check("skip_frame_cnt", 320'(frame_cnt), 320'(fc_exp));
        end else begin
            ack_frame();
            repeat (run_len) step();
            end_frame();
        end
    endtask

    vec_t vecs[8];
    bit   saw_start;

    initial begin
        vecs[0] = '{32'd12,    32'd12};
        vecs[1] = '{32'd20000, 32'd16384};
        vecs[2] = '{32'd13,    32'd12};
        vecs[3] = '{32'd16385, 32'd16384};
        vecs[4] = '{32'd16384, 32'd16384};
        vecs[5] = '{32'd3,     32'd0};
        vecs[6] = '{32'd0,     32'd0};
        vecs[7] = '{32'd100,   32'd100};

        ident = '0;
        for (int i = 0; i < 4; i++) ident[i*5] = fixed_t'(18'sh80);

        reset_n = 1'b0; frame_tick = 1'b0; frame_end = 1'b1;
        host_if.host_mtx_we = 1'b0; host_if.host_mtx_idx = '0; host_if.host_mtx_data = '0;
        host_if.host_vcount = '0; host_if.host_commit = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        step();

        check("rst_start", 320'(gpu_start), 320'(0));
        check("rst_busy", 320'(busy), 320'(0));
        check("rst_vcount", 320'(gpu_vertex_count), 320'(0));
        check("rst_matrix", 320'(gpu_transform_matrix), 320'(0));
        check("rst_frame_cnt", 320'(frame_cnt), 320'(0));
        check("rst_drop_cnt", 320'(drop_cnt), 320'(0));
        check("rst_timeout", 320'(timeout), 320'(0));

        // Identity matrix frame.
        for (int i = 0; i < 4; i++) write_elem(i*5, fixed_t'(18'sh80));
        commit(32'd12, 32'd12);
        start_frame(0, '0, '0);
        check("identity_matrix", 320'(gpu_transform_matrix), 320'(ident));
        finish_frame(3);

        // Vertex count clamp table.
        foreach (vecs[i]) begin
            commit(vecs[i].vc_in, vecs[i].vc_exp);
            start_frame(0, '0, '0);
            check("clamp_vcount", 320'(gpu_vertex_count), 320'(vecs[i].vc_exp));
            finish_frame(2 + i);
        end

        // Commit during RUN applies at the next LOAD.
        start_frame(0, '0, '0);
        ack_frame();
        write_elem(0, fixed_t'(18'sh100));
        commit(32'd24, 32'd24);
        check("run_commit_held", 320'(gpu_vertex_count), 320'(last_vc));
        end_frame();
        start_frame(0, '0, '0);
        finish_frame(2);

        // Commit in the LOAD cycle is deferred one frame.
        start_frame(1, 32'd40, 32'd40);
        finish_frame(2);
        start_frame(0, '0, '0);
        check("load_commit_applied", 320'(gpu_vertex_count), 320'(40));
        ack_frame();

        // Three ticks during RUN are dropped.
        saw_start = 0;
        repeat (3) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            if (gpu_start) saw_start = 1;
            step();
            if (gpu_start) saw_start = 1;
        end
        drop_exp = drop_exp + Fcw'(3);
        check("drop_in_run", 320'(drop_cnt), 320'(drop_exp));
        check("no_extra_start", 320'(saw_start), 320'(0));
        end_frame();

        // Tick in IDLE with GPU not idle is dropped.
        frame_end = 1'b0;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        drop_exp = drop_exp + Fcw'(1);
        step();
        check("drop_idle", 320'(drop_cnt), 320'(drop_exp));
        check("drop_idle_no_start", 320'(gpu_start), 320'(0));
        check("drop_idle_busy", 320'(busy), 320'(0));
        frame_end = 1'b1;
        step();

        // Reset mid-RUN.
        start_frame(0, '0, '0);
        ack_frame();
        step();
        reset_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_busy", 320'(busy), 320'(0));
        check("mid_rst_matrix", 320'(gpu_transform_matrix), 320'(0));
        check("mid_rst_vcount", 320'(gpu_vertex_count), 320'(0));
        check("mid_rst_frame_cnt", 320'(frame_cnt), 320'(0));
        check("mid_rst_drop_cnt", 320'(drop_cnt), 320'(0));
        frame_end = 1'b1;
        @(posedge clk);
        #1 reset_n = 1'b1;
        step();
        start_frame(0, '0, '0);
        finish_frame(1);

`ifdef GPU_FRAME_SCHEDULER_WATCHDOG_EN
        commit(32'd8, 32'd8);
        start_frame(0, '0, '0);
        step();
        frame_end = 1'b0;
        repeat (99) step();
        check("wd_not_yet", 320'(timeout), 320'(0));
        step();
        check("wd_timeout", 320'(timeout), 320'(1));
        check("wd_busy", 320'(busy), 320'(0));
        check("wd_frame_cnt", 320'(frame_cnt), 320'(fc_exp));
        frame_end = 1'b1;
        step();
        model_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
`endif

        // drop_cnt wrap: hold a tick with the GPU not idle.
        saw_start = 0;
        frame_end = 1'b0;
        frame_tick = 1'b1;
        for (int n = 0; n < 70000 && drop_cnt !== 16'hFFFF; n++) begin
            step();
            if (gpu_start) saw_start = 1;
        end
        check("drop_max", 320'(drop_cnt), 320'(16'hFFFF));
        step();
        check("drop_wrap", 320'(drop_cnt), 320'(0));
        check("wrap_no_start", 320'(saw_start), 320'(0));
        frame_tick = 1'b0;
        frame_end = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
